wb_spi_flash_ctrl: RTL
======================

Name: wb_spi_flash_ctrl

Overview:
- Wishbone pipelined slave that serves CPU instruction and data reads from an external SPI NOR flash.
- Replaces the on-chip program-memory array on the flash crossbar slot at 0x01000000.
- Turns each single-word read into one SPI READ (0x03) transaction: command, 24-bit address, optional dummy clocks, 32 data bits.
- Read-only; writes return an error.

Parameters:
- CLK_DIV, 2: SCK half-period in wb_clk_i cycles; minimum 1.
- DUMMY_CYCLES, 0: SCK cycles inserted between address and data; range 0..15.
- WAKE_WAIT, 1000: wb_clk_i cycles to wait after the wake command. Used only with SPIFLASH_WAKEUP_EN.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable; writes are rejected with error.
- wb_adr_i  in  32  byte address; bits [23:2] are used.
- wb_dat_i  in  32  write data; ignored.
- wb_sel_i  in  4  byte select; ignored, a full word is always returned.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  read complete.
- wb_err_o  out  1  write rejected.
- wb_stall_o  out  1  not ready to accept a request.
- spi_sck_o  out  1  SPI clock, mode 0, idles low.
- spi_cs_n_o  out  1  chip select, active low.
- spi_mosi_o  out  1  serial data to flash.
- spi_miso_i  in  1  serial data from flash.

Behaviour:
- Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, wb_stall_o=0 (1 while WAKE runs if the macro is defined), spi_sck_o=0, spi_cs_n_o=1, spi_mosi_o=0. FSM state is IDLE.
- Reset asserted mid-transaction: CS high and SCK low immediately (asynchronous). No ack is issued.
- Acceptance: a request is accepted on a cycle with wb_cyc_i & wb_stb_i & !wb_stall_o.
- wb_stall_o is 1 in every state except IDLE.
- Write accepted: wb_err_o=1 for exactly one cycle on the next clock. No SPI activity, stall stays 0.
- Read accepted: latch flash address {wb_adr_i[23:2],2'b00}, go to CMD.
- FSM states and transitions:
  - IDLE -> CMD on read acceptance.
  - CMD: 8 bits 0x03. Then ADDR: 24 bits.
  - DUMMY: DUMMY_CYCLES SCK cycles, MOSI=0. Skipped when the parameter is 0.
  - DATA: 32 bits. Then DONE, then GAP, then IDLE.
- Bit timing:
  - The cycle after acceptance: CS low and MOSI = first bit (MSB first).
  - SCK toggles every CLK_DIV cycles.
  - MOSI changes on SCK falling edges; MISO is sampled on SCK rising edges.
- Data assembly: the first received byte goes to wb_dat_o[7:0], the second to [15:8], the third to [23:16], the fourth to [31:24]. Each byte is MSB-first on the wire.
- DONE: CS high, SCK low. wb_dat_o updated and wb_ack_o=1 for exactly one cycle.
- Latency: ack is asserted exactly 2 + (64+DUMMY_CYCLES)*2*CLK_DIV cycles after the acceptance cycle. With defaults this is 258.
- GAP: CS held high for 2*CLK_DIV cycles, then IDLE.
- wb_dat_o holds its value until the next ack; it is not cleared.
- wb_cyc_i deasserted during CMD..DATA (abort):
  - Next cycle: CS high, SCK low, enter GAP.
  - No ack is issued and wb_dat_o is unchanged.
- Never more than one outstanding request.
- wb_ack_o and wb_err_o never assert in the same cycle.
- wb_stb_i while stalled is ignored; the crossbar holds it.

Optional Feature:
- Macro SPIFLASH_WAKEUP_EN.
- Defined:
  - After reset release the FSM enters WAKE instead of IDLE.
  - WAKE sends the single byte 0xAB with the same bit timing, deasserts CS, then waits WAKE_WAIT cycles before entering IDLE.
  - wb_stall_o=1 throughout WAKE, so requests queue in the crossbar.
- Not defined: after reset the FSM enters IDLE directly, with wb_stall_o=0.

Test Plan:
- Read with flash model word 0x12345678 at byte addr 0x000010 (bytes 78 56 34 12), wb_adr_i=0x01000010 -> MOSI carries 0x03, 0x000010; ack at cycle 258 after accept; wb_dat_o=0x12345678; CS high for 4 cycles before stall drops.
- Write to 0x01000000 -> wb_err_o high for exactly one cycle on the next clock; spi_cs_n_o stays 1; no ack.
- DUMMY_CYCLES=8, CLK_DIV=1, read addr 0x0000FC -> eight SCK cycles with MOSI=0 after address; ack exactly 2+72*2=146 cycles after accept; data correct.
- Two reads issued back to back -> second is stalled until GAP ends; two separate CS-low windows; two acks with correct, distinct data.
- wb_cyc_i dropped during ADDR -> CS high next cycle; no ack ever; the next read returns correct data.
- Reset asserted mid-DATA -> spi_cs_n_o=1, spi_sck_o=0 and wb_ack_o=0 with no clock edge. With SPIFLASH_WAKEUP_EN and WAKE_WAIT=10: 0xAB sent, stall high until 10 cycles after CS rises.

Source files
------------

// File: rtl/wb_spi_flash_ctrl.sv
// rtl/wb_spi_flash_ctrl.sv - Wishbone pipelined read-only slave backed by SPI NOR flash (READ 0x03).
// Optional power-up wake command (0xAB) enabled by SPIFLASH_WAKEUP_EN.
module wb_spi_flash_ctrl #(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 0,
    parameter int WAKE_WAIT    = 1000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    output logic        spi_sck_o,
    output logic        spi_cs_n_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_GAP, S_WAKE, S_WAKE_WAIT
    } state_t;

`ifdef SPIFLASH_WAKEUP_EN
    localparam logic WAKE_EN = 1'b1;
`else
    localparam logic WAKE_EN = 1'b0;
`endif

    state_t      state, state_d;
    logic [31:0] cnt;
    logic [4:0]  bit_cnt, bit_load;
    logic        sck;
    logic [31:0] sr_out, sr_in;
    logic        wake_pending;
    logic [31:0] dat_q;
    logic        ack_q, err_q;
    logic        shifting, in_xfer, half_done, rise, fall, bit_last, accept;

    logic unused_ok;
    assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24], wb_adr_i[1:0]};

    always_comb begin
        shifting  = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_WAKE};
        in_xfer   = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
        half_done = (cnt == 32'(CLK_DIV - 1));
        rise      = shifting && half_done && !sck;
        fall      = shifting && half_done && sck;
        bit_last  = fall && (bit_cnt == 5'd0);
        accept    = wb_cyc_i && wb_stb_i && !wb_stall_o;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d  = state;
        bit_load = 5'd7;
        if (in_xfer && !wb_cyc_i) begin
            state_d = S_GAP;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wake_pending)              state_d = S_WAKE;
                    else if (accept && !wb_we_i)   state_d = S_CMD;
                end
                S_CMD:   if (bit_last) state_d = S_ADDR;
                S_ADDR:  if (bit_last) state_d = (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
                S_DUMMY: if (bit_last) state_d = S_DATA;
                S_DATA:  if (bit_last) state_d = S_DONE;
                S_DONE:  state_d = S_GAP;
                S_GAP:   if (cnt == 32'(2 * CLK_DIV - 1)) state_d = S_IDLE;
                S_WAKE:  if (bit_last) state_d = S_WAKE_WAIT;
                S_WAKE_WAIT: if (cnt == 32'(WAKE_WAIT - 1)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        case (state_d)
            S_ADDR:  bit_load = 5'd23;
            S_DUMMY: bit_load = 5'(DUMMY_CYCLES - 1);
            S_DATA:  bit_load = 5'd31;
            default: bit_load = 5'd7;
        endcase
    end

    // cnt doubles as SCK half-period divider and GAP/WAKE_WAIT timer
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            sck          <= 1'b0;
            sr_out       <= '0;
            sr_in        <= '0;
            wake_pending <= WAKE_EN;
            dat_q        <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ack_q        <= (state == S_DONE);
            err_q        <= accept && wb_we_i;
            wake_pending <= wake_pending && (state != S_IDLE);

            if (state == S_DONE)
                dat_q <= {sr_in[7:0], sr_in[15:8], sr_in[23:16], sr_in[31:24]};

            if (state_d != state || state == S_IDLE || (shifting && half_done))
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;

            if (!shifting || state_d == S_GAP) sck <= 1'b0;
            else if (half_done)                sck <= !sck;

            if (state_d != state) bit_cnt <= bit_load;
            else if (fall)        bit_cnt <= bit_cnt - 5'd1;

            if (state == S_IDLE && state_d == S_CMD)
                sr_out <= {8'h03, wb_adr_i[23:2], 2'b00};
            else if (state == S_IDLE && state_d == S_WAKE)
                sr_out <= {8'hAB, 24'h000000};
            else if (fall)
                sr_out <= {sr_out[30:0], 1'b0};

            if (rise && state == S_DATA)
                sr_in <= {sr_in[30:0], spi_miso_i};
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_stall_o = (state != S_IDLE) || wake_pending;
    assign spi_sck_o  = sck;
    assign spi_cs_n_o = !shifting;
    assign spi_mosi_o = (state == S_CMD || state == S_ADDR || state == S_WAKE) && sr_out[31];

endmodule
